lsu_data_mem: RTL

//  RV32 load/store data memory: DEPTH words, byte-addressed, little-endian.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu_data_mem.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the RV32 load/store data memory.
//   lsu_state_e : FSM states (IDLE, WAIT, RESP)
//   F3_*        : RV32 funct3 encodings for the supported access sizes
//   lsu_req_t   : latched request {we, funct3, addr, wdata}
//   f3_legal()  : funct3 legality check for a load or a store
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Stores only have signed-size encodings; loads also allow the unsigned forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for the data memory.
//   we_i, funct3_i, lane_i : access type and byte offset within the word
//   wdata_i                : store data from rs2
//   rword_i                : raw memory word for loads
//   byte_en_o              : per-lane write enables for stores
//   wdata_o                : store data replicated into every candidate lane
//   misalign_o, illegal_o  : alignment / encoding faults
//   rdata_o                : sign- or zero-extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    illegal_o  = !f3_legal(we_i, funct3_i);
    misalign_o = 1'b0;
    byte_en_o  = 4'b0000;
    wdata_o    = wdata_i;
    case (funct3_i)
      F3_H, F3_HU: misalign_o = lane_i[0];
      F3_W:        misalign_o = |lane_i;
      default:     misalign_o = 1'b0;
    endcase
    // Replicating the store data lets byte_en alone pick the destination lane.
    case (funct3_i)
      F3_B: begin
        byte_en_o = 4'b0001 << lane_i;
        wdata_o   = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        byte_en_o = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        byte_en_o = 4'b1111;
        wdata_o   = wdata_i;
      end
      default: begin
        byte_en_o = 4'b0000;
        wdata_o   = wdata_i;
      end
    endcase
  end

  always_comb begin
    b_lane  = rword_i[8*lane_i +: 8];
    h_lane  = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    rdata_o = rword_i;
    case (funct3_i)
      F3_B:    rdata_o = {{24{b_lane[7]}}, b_lane};
      F3_BU:   rdata_o = {24'h000000, b_lane};
      F3_H:    rdata_o = {{16{h_lane[15]}}, h_lane};
      F3_HU:   rdata_o = {16'h0000, h_lane};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/lsu_data_mem.sv
// lsu_data_mem: RV32 load/store data memory with configurable read latency.
//   clk, reset            : clock and synchronous active-high reset
//   req_valid / req_ready : request handshake from the core
//   req_we, req_funct3    : store flag and RV32 access size/sign
//   req_addr, req_wdata   : byte address and store data
//   rsp_valid             : one-cycle response pulse, LATENCY cycles after accept
//   rsp_rdata, rsp_fault  : extended load data (0 for stores/faults) and fault flag
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int          IW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  lsu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  lsu_req_t    req_q;
  lsu_req_t    req_in;
  lsu_req_t    creq;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          commit;
  logic          wr_en;
  logic [31:0]   offset;
  logic          range_fault;
  logic [IW-1:0] idx;
  logic [31:0]   rword;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_sh;
  logic          misalign;
  logic          illegal;
  logic [31:0]   ext_rdata;
  logic          fault;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;
  assign accept    = req_valid && req_ready;

  assign req_in = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

  // With single-cycle latency the commit edge is the accept edge, so the
  // access is performed straight from the port instead of the request register.
  assign commit = (LATENCY == 1) ? accept : ((state_q == WAIT) && (cnt_q == 4'd1));
  assign creq   = (LATENCY == 1) ? req_in : req_q;

  assign offset      = creq.addr - BASE_ADDR;
  assign range_fault = offset >= SPAN;
  assign idx         = offset[2 +: IW];
  assign rword       = mem_q[idx];
  assign fault       = illegal || misalign || range_fault;
  assign wr_en       = commit && !reset && creq.we && !fault;

  lsu_align u_align (
    .we_i       (creq.we),
    .funct3_i   (creq.funct3),
    .lane_i     (creq.addr[1:0]),
    .wdata_i    (creq.wdata),
    .rword_i    (rword),
    .byte_en_o  (byte_en),
    .wdata_o    (wdata_sh),
    .misalign_o (misalign),
    .illegal_o  (illegal),
    .rdata_o    (ext_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          cnt_d = CNT_INIT;
          if (LATENCY == 1) state_d = RESP;
          else              state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accept boundary: request captured for the commit edge.
  always_ff @(posedge clk) begin
    if (accept) req_q <= req_in;
  end

  // Commit boundary: memory update and response registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else if (commit) begin
      fault_q <= fault;
      rdata_q <= (fault || creq.we) ? 32'h0 : ext_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
